// File: rtl/spi_display_receiver.sv
// SPI responder for MAX7219-style 16-bit display frames, sampled in the clk domain.
// Optional Code-B segment decoding on the digit read port is built when SPI_RX_CODEB_EN is defined.
module spi_display_receiver #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       shutdown,
  output logic       display_test,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic [7:0] decode_mode,
  input  logic [2:0] rd_sel,
  output logic [7:0] rd_data
);

  localparam int unsigned CNT_W   = $clog2(FRAME_BITS + 1);
  localparam int unsigned DIGITS  = 8;
  localparam int unsigned PIN_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Synchronizer chain for {sclk, cs, mosi}; cs resets low so a CS held low
  // through reset never produces a falling edge.
  logic [PIN_W-1:0] sync_q [SYNC_STAGES];
  logic [1:0]       prev_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, cs_rise, cs_fall;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  shutdown_q, shutdown_d;
  logic                  display_test_q, display_test_d;
  logic [3:0]            intensity_q, intensity_d;
  logic [2:0]            scan_limit_q, scan_limit_d;
  logic [7:0]            decode_mode_q, decode_mode_d;
  logic [7:0]            digit_q [DIGITS];
  logic [7:0]            digit_d [DIGITS];

  logic [3:0] addr;
  logic [7:0] data;
  logic       unused_hdr;

  assign sclk_s = sync_q[SYNC_STAGES-1][2];
  assign cs_s   = sync_q[SYNC_STAGES-1][1];
  assign mosi_s = sync_q[SYNC_STAGES-1][0];

  assign sclk_rise = sclk_s & ~prev_q[1];
  assign cs_rise   = cs_s & ~prev_q[0];
  assign cs_fall   = ~cs_s & prev_q[0];

  assign addr       = sr_q[11:8];
  assign data       = sr_q[7:0];
  assign unused_hdr = ^sr_q[FRAME_BITS-1:12];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {sclk, cs, mosi};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= {sclk_s, cs_s};
    end
  end

  // State and register file
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q        <= ST_IDLE;
      sr_q           <= '0;
      cnt_q          <= '0;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
      shutdown_q     <= 1'b1;
      display_test_q <= 1'b0;
      intensity_q    <= '0;
      scan_limit_q   <= '0;
      decode_mode_q  <= '0;
      for (int i = 0; i < int'(DIGITS); i++) digit_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      cnt_q          <= cnt_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
      shutdown_q     <= shutdown_d;
      display_test_q <= display_test_d;
      intensity_q    <= intensity_d;
      scan_limit_q   <= scan_limit_d;
      decode_mode_q  <= decode_mode_d;
      for (int i = 0; i < int'(DIGITS); i++) digit_q[i] <= digit_d[i];
    end
  end

  // Next-state, shifting and frame decode; a CS rise takes priority over a coincident SCLK rise
  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    cnt_d          = cnt_q;
    frame_valid_d  = 1'b0;
    frame_err_d    = 1'b0;
    shutdown_d     = shutdown_q;
    display_test_d = display_test_q;
    intensity_d    = intensity_q;
    scan_limit_d   = scan_limit_q;
    decode_mode_d  = decode_mode_q;
    for (int i = 0; i < int'(DIGITS); i++) digit_d[i] = digit_q[i];

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_COMMIT;
          if (cnt_q == CNT_W'(FRAME_BITS)) begin
            frame_valid_d = 1'b1;
            case (addr)
              4'h1, 4'h2, 4'h3, 4'h4,
              4'h5, 4'h6, 4'h7, 4'h8: digit_d[3'(addr - 4'd1)] = data;
              4'h9:    decode_mode_d  = data;
              4'hA:    intensity_d    = data[3:0];
              4'hB:    scan_limit_d   = data[2:0];
              4'hC:    shutdown_d     = ~data[0];
              4'hF:    display_test_d = data[0];
              default: ;
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          sr_d = {sr_q[FRAME_BITS-2:0], mosi_s};
          if (cnt_q != CNT_W'(FRAME_BITS)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign frame_valid  = frame_valid_q;
  assign frame_err    = frame_err_q;
  assign shutdown     = shutdown_q;
  assign display_test = display_test_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign decode_mode  = decode_mode_q;

`ifdef SPI_RX_CODEB_EN
  // Code-B font, segments {A,B,C,D,E,F,G}
  function automatic logic [6:0] code_b(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h01;
      4'hB: seg = 7'h4F;
      4'hC: seg = 7'h37;
      4'hD: seg = 7'h0E;
      4'hE: seg = 7'h67;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  always_comb begin
    rd_data = digit_q[rd_sel];
    if (decode_mode_q[rd_sel]) rd_data = {digit_q[rd_sel][7], code_b(digit_q[rd_sel][3:0])};
  end
`else
  assign rd_data = digit_q[rd_sel];
`endif

endmodule
